// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory target for the MIPS load/store port.
// It accepts one access at a time, inserts WAIT_CYCLES wait states, and then
// answers with a one-cycle ready strobe. Misaligned or out-of-range addresses
// are answered with err after one cycle and do not touch the array.
//
// Handshake: req, we, addr and wdata are sampled only on a clock edge where the
// block is idle (busy=0). busy then stays high up to and including the cycle in
// which ready=1. A req seen while busy is dropped rather than queued, so the
// requester must hold req or issue it again after ready. ready lasts exactly one
// cycle. rdata is meaningful with ready for a valid load and holds until the
// next response. err is meaningful only with ready.
module dmem_responder #(
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic [31:0]           mem_q [DEPTH];

    // The access that completes on this edge. With zero wait states it comes
    // straight from the inputs, because the latched copy is not loaded yet.
    logic                  commit;
    logic                  acc_we;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [31:0]           acc_wdata;

    logic                  req_bad;
    logic [DEPTH_LOG2-1:0] req_idx;

    assign req_idx = addr[DEPTH_LOG2+1:2];
    assign req_bad = (addr[1:0] != 2'b00) || (addr[31:DEPTH_LOG2+2] != '0);

    // Next-state and next-output logic. Outputs are computed one edge early
    // so that every output port comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        commit    = 1'b0;
        acc_we    = we_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    idx_d   = req_idx;
                    wdata_d = wdata;
                    if (req_bad) begin
                        // Rejected accesses skip the wait states entirely.
                        state_d = S_RESP;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d   = S_RESP;
                        commit    = 1'b1;
                        acc_we    = we;
                        acc_idx   = req_idx;
                        acc_wdata = wdata;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit) begin
            ready_d = 1'b1;
            rdata_d = acc_we ? '0 : mem_q[acc_idx];
        end

        busy_d = (state_d != S_IDLE);
    end

    // State register, latched request fields and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array. A store is committed on the edge that enters RESP and
    // reset clears every word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit && acc_we) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign rdata     = rdata_q;
    assign ready     = ready_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. It uses a table of directed accesses, random
// accesses checked against an array model, and hand-written sequences for
// dropped requests, zero-wait streaming and reset in the middle of an access.
module tb_dmem_responder;

    localparam int DL2 = 6;
    localparam int WC  = 2;
    localparam int WORDS = 1 << DL2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // DUT with the default wait states
    logic        req, we;
    logic [31:0] addr, wdata, rdata;
    logic        ready, err, busy;
    logic [1:0]  dbg_state;

    // DUT with zero wait states
    logic        req0, we0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ready0, err0, busy0;
    logic [1:0]  dbg_state0;

    dmem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .busy(busy), .dbg_state(dbg_state)
    );

    dmem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0), .dbg_state(dbg_state0)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int passes = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_mem [WORDS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: the memory is a plain array of words. A byte address
    // is legal when it is word aligned and below WORDS*4.
    function automatic bit model_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= WORDS * 4);
    endfunction

    task automatic model_apply(input logic w, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] erd, output logic eerr);
        eerr = model_bad(a);
        erd  = 32'h0;
        if (!eerr) begin
            if (w) model_mem[a / 4] = d;
            else   erd = model_mem[a / 4];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < WORDS; i++) model_mem[i] = 32'h0;
    endtask

    // ---------------- driver ----------------
    // One access on dut. It checks latency, busy coverage, response fields
    // and the return to idle.
    task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] erd, input logic eerr, input string tag);
        int c;
        int elat;
        bit busy_ok;
        elat = eerr ? 1 : 1 + WC;
        exp_q.push_back(erd);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
        c = 1;
        busy_ok = busy;
        while (!ready && c < 20) begin
            @(negedge clk);
            c++;
            if (!busy) busy_ok = 1'b0;
        end
        chk({tag, " latency"}, c, elat);
        chk({tag, " busy"}, {31'h0, busy_ok}, 32'h1);
        chk({tag, " err"}, {31'h0, err}, {31'h0, eerr});
        chk({tag, " rdata"}, rdata, exp_q.pop_front());
        @(negedge clk);
        chk({tag, " idle"}, {29'h0, ready, err, busy}, 32'h0);
    endtask

    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input string tag);
        logic [31:0] erd;
        logic        eerr;
        model_apply(w, a, d, erd, eerr);
        run_access(w, a, d, erd, eerr, tag);
    endtask

    // One single-cycle store on dut0.
    task automatic store0(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = a; wdata0 = d;
        @(negedge clk);
        req0 = 1'b0; we0 = 1'b0;
        chk("w0 store ready", {30'h0, ready0, busy0}, 32'h3);
        chk("w0 store err", {31'h0, err0}, 32'h0);
        @(negedge clk);
        chk("w0 store idle", {30'h0, ready0, busy0}, 32'h0);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        eerr;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [31:0] seq_a [6];
        logic [31:0] seq_rd [6];
        logic        seq_rdy [6];
        logic [31:0] ign_rd;
        int pulses;
        int first;
        bit busy_ok;

        tbl[0]  = '{1'b0, 32'h0000_0000, 32'h0,           1'b0, 32'h0};
        tbl[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF,   1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0000_0010, 32'h0,           1'b0, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b0, 32'h0000_000C, 32'h0,           1'b0, 32'h0};
        tbl[4]  = '{1'b0, 32'h0000_0014, 32'h0,           1'b0, 32'h0};
        tbl[5]  = '{1'b0, 32'h0000_0012, 32'h0,           1'b1, 32'h0};
        tbl[6]  = '{1'b1, 32'h0000_0100, 32'h1111_1111,   1'b1, 32'h0};
        tbl[7]  = '{1'b0, 32'h0000_0000, 32'h0,           1'b0, 32'h0};
        tbl[8]  = '{1'b1, 32'h0000_00FC, 32'h1234_5678,   1'b0, 32'h0};
        tbl[9]  = '{1'b0, 32'h0000_00FC, 32'h0,           1'b0, 32'h1234_5678};
        tbl[10] = '{1'b1, 32'h8000_0000, 32'h2222_2222,   1'b1, 32'h0};
        tbl[11] = '{1'b0, 32'h0000_0003, 32'h0,           1'b1, 32'h0};
        tbl[12] = '{1'b1, 32'h0000_0004, 32'hA5A5_A5A5,   1'b0, 32'h0};
        tbl[13] = '{1'b0, 32'h0000_0004, 32'h0,           1'b0, 32'hA5A5_A5A5};

        req = 0; we = 0; addr = 0; wdata = 0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        model_reset();

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {29'h0, ready, err, busy}, 32'h0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset outputs w0", {29'h0, ready0, err0, busy0}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("post-reset idle", {29'h0, ready, err, busy}, 32'h0);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            logic [31:0] unused_rd;
            logic        unused_err;
            model_apply(tbl[i].w, tbl[i].a, tbl[i].d, unused_rd, unused_err);
            run_access(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].erd, tbl[i].eerr,
                       $sformatf("tbl%0d", i));
        end

        // Random accesses against the model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 6)      a = 32'($urandom_range(0, 15)) * 4;
            else if (kind == 7) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
            else                a = ($urandom() & 32'hFFFF_FFFC) | 32'h0000_0100;
            model_access(1'($urandom_range(0, 1)), a, $urandom(), $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // A req during WAIT is dropped. The store to 0x20 must not happen.
        ign_rd = model_mem[4];
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h10;
        pulses = 0; first = 0; busy_ok = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (ready) begin
                pulses++;
                if (first == 0) begin
                    first = c;
                    chk("ign rdata", rdata, ign_rd);
                    chk("ign err", {31'h0, err}, 32'h0);
                end
            end
            if (c <= 1 + WC && !busy) busy_ok = 1'b0;
            if (c == 1) begin
                req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hFFFF_FFFF;
            end else begin
                req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
            end
        end
        chk("ign pulses", pulses, 1);
        chk("ign latency", first, 1 + WC);
        chk("ign busy", {31'h0, busy_ok}, 32'h1);
        model_access(1'b0, 32'h20, 32'h0, "ign readback");

        // Zero wait states with req held high: a response every second cycle
        store0(32'h08, 32'hCAFE_F00D);
        store0(32'h0C, 32'h0BAD_F00D);
        seq_a[0] = 32'h08; seq_rdy[0] = 1'b1; seq_rd[0] = 32'hCAFE_F00D;
        seq_a[1] = 32'h40; seq_rdy[1] = 1'b0; seq_rd[1] = 32'h0;
        seq_a[2] = 32'h0C; seq_rdy[2] = 1'b1; seq_rd[2] = 32'h0BAD_F00D;
        seq_a[3] = 32'h44; seq_rdy[3] = 1'b0; seq_rd[3] = 32'h0;
        seq_a[4] = 32'h08; seq_rdy[4] = 1'b1; seq_rd[4] = 32'hCAFE_F00D;
        seq_a[5] = 32'h48; seq_rdy[5] = 1'b0; seq_rd[5] = 32'h0;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("stream%0d ready", i - 1), {31'h0, ready0}, {31'h0, seq_rdy[i-1]});
                chk($sformatf("stream%0d busy", i - 1), {31'h0, busy0}, {31'h0, seq_rdy[i-1]});
                if (seq_rdy[i-1]) chk($sformatf("stream%0d rdata", i - 1), rdata0, seq_rd[i-1]);
            end
            if (i < 6) begin
                req0 = 1'b1; we0 = 1'b0; addr0 = seq_a[i];
            end else begin
                req0 = 1'b0; addr0 = 32'h0;
            end
        end

        // Reset during WAIT aborts the store and clears the array.
        model_access(1'b1, 32'h10, 32'h7777_7777, "pre-reset store");
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h55AA_55AA;
        @(negedge clk);
        req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
        chk("mid busy", {31'h0, busy}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("mid reset outputs", {29'h0, ready, err, busy}, 32'h0);
        chk("mid reset rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        pulses = 0; busy_ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ready) pulses++;
            if (busy) busy_ok = 1'b0;
        end
        chk("mid no ready", pulses, 0);
        chk("mid idle", {31'h0, busy_ok}, 32'h1);
        model_access(1'b0, 32'h20, 32'h0, "mid readback 0x20");
        model_access(1'b0, 32'h10, 32'h0, "mid readback 0x10");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the MIPS core: the target end of the load/store interface the datapath drives (address = ALU result, write data = rt, read data returned to the result mux). Word-addressed store with a req/ready handshake and a programmable wait-state counter, so multicycle and stall-capable datapath variants can be exercised against realistic memory latency. Decodes misaligned and out-of-range accesses and reports them as an error response instead of touching the array.

Parameters:
DEPTH_LOG2, 6, log2 of word count (64 words)
WAIT_CYCLES, 2, wait states inserted between accept and response (0..15)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous active-low reset (0 = reset)
req  input  1  access request from datapath, sampled only in IDLE
we  input  1  1 = store (sw), 0 = load (lw); sampled with req
addr  input  32  byte address (aluout)
wdata  input  32  store data (writedata)
rdata  output  32  load data; valid when ready=1 and we_q=0
ready  output  1  one-cycle response strobe
err  output  1  asserted with ready when the access was rejected
busy  output  1  high from the accept cycle until the response cycle inclusive

Behaviour:
- Reset (rst=0, async): state=IDLE, rdata=0, ready=0, err=0, busy=0, wait counter=0, every memory word cleared to 0. Deassertion synchronous to clk.
- Registered outputs only; no combinational path from req/addr to ready/rdata.
- States: IDLE, WAIT, RESP.
- IDLE: if req=1 at a clock edge -> latch we, addr, wdata; busy=1 from that edge onward.
  - addr[1:0]!=0 or addr[31:DEPTH_LOG2+2]!=0 -> go to RESP with err_q=1 (no wait states, no array access).
  - else if WAIT_CYCLES=0 -> RESP; else -> WAIT with counter=WAIT_CYCLES-1.
- WAIT: counter decrements each cycle; at counter=0 -> RESP next edge.
- RESP (one cycle): ready=1, err=err_q.
  - Valid load: rdata = mem[addr_q[DEPTH_LOG2+1:2]].
  - Valid store: mem[index] <= wdata_q committed on the edge entering RESP; rdata=0.
  - Error: rdata=0, no write.
  - Next edge -> IDLE, ready=0, err=0, busy=0. rdata holds its value until the next response.
- Latency, valid access: request edge at cycle N -> ready high during cycle N+1+WAIT_CYCLES. Error: ready high during cycle N+1.
- req while busy is ignored (not queued); the requester must hold req or re-issue after ready.
- req held high through RESP: a new access is accepted on the first edge in IDLE, i.e. one idle cycle separates back-to-back accesses.
- Read-after-write to the same word in consecutive accesses returns the new data.
- Reset mid-access (WAIT or RESP): transaction aborted, no write committed if reset precedes the commit edge, outputs at reset values.

Test Plan:
- Reset then load addr=0x0 (WAIT_CYCLES=2) -> ready pulses exactly 3 cycles after the request edge, rdata=0x00000000, err=0.
- Store addr=0x10 wdata=0xDEADBEEF, then load 0x10 -> store ready with err=0; load returns 0xDEADBEEF; words 0x0C and 0x14 still read 0.
- Misaligned load addr=0x12 and out-of-range store addr=0x100 (DEPTH_LOG2=6) -> ready+err one cycle after request, rdata=0; a subsequent load of 0x00 confirms no write occurred.
- Pulse req during WAIT with different addr -> ignored; only the original transaction responds, busy stays high throughout, single ready pulse.
- Rebuild with WAIT_CYCLES=0, hold req high for 6 cycles streaming loads -> ready every second cycle, one idle cycle between responses.
- Store to 0x20 with rst pulsed low during WAIT -> no ready pulse; after reset, load 0x20 returns 0 and busy=0.
